// File: rtl/rom_reader_pkg.sv
// rom_reader_pkg: shared types and constants for the ROM burst reader slice.
//   state_t      - burst controller states
//   *_DEF        - default widths used by the top level
//   ROM_LATENCY  - cycles from rom_cs to valid rom_dout
//   BUF_DEPTH    - entries in the output buffer (also the issue credit limit)
package rom_reader_pkg;

  localparam int unsigned ADDR_W_DEF  = 8;
  localparam int unsigned DATA_W_DEF  = 8;
  localparam int unsigned LEN_W_DEF   = 9;
  localparam int unsigned ROM_LATENCY = 1;
  localparam int unsigned BUF_DEPTH   = 2;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN
  } state_t;

endpackage

// File: rtl/rom_reader_fifo2.sv
// rom_reader_fifo2: two-entry FIFO with simultaneous push/pop.
//   clk, rst   - clock, asynchronous active-high reset (flushes contents)
//   push       - write push_data at the tail
//   push_data  - byte to store
//   pop        - drop the head entry
//   head       - current head entry (0 after reset)
//   count      - number of stored entries (0..2)
module rom_reader_fifo2
  import rom_reader_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem [BUF_DEPTH];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        cnt;
  logic              pop_ok;
  logic              push_ok;

  // Guard against misuse: pops on empty and pushes on a full buffer without a
  // matching pop are dropped.
  assign pop_ok  = pop & (cnt != 2'd0);
  assign push_ok = push & ((cnt != 2'd2) | pop_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/rom_burst_reader.sv
// rom_burst_reader: burst read front end for a synchronous 1-cycle-latency ROM.
//   clk, rst        - clock, asynchronous active-high reset
//   start           - command strobe, sampled only while busy=0
//   start_addr      - first ROM address of the burst
//   length          - bytes to deliver (0 gives an immediate done)
//   busy            - burst in progress
//   done            - one-cycle completion pulse
//   rom_cs/rom_addr - ROM macro read strobe and address
//   rom_dout        - ROM read data, valid the cycle after rom_cs
//   out_valid/out_ready/out_data - byte output stream
module rom_burst_reader
  import rom_reader_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic              rom_cs,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  localparam logic [2:0] CREDIT = 3'(BUF_DEPTH);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] last_addr;
  logic [LEN_W-1:0]  issue_rem;
  logic [LEN_W-1:0]  deliver_rem;
  logic              in_flight;
  logic              done_q;
  logic [1:0]        fifo_count;
  logic [DATA_W-1:0] fifo_head;
  logic              pop;
  logic              issue;
  logic              accept;
  logic              accept_zero;
  logic              last_pop;
  logic [2:0]        committed;

  assign out_valid = (fifo_count != 2'd0);
  assign pop       = out_valid & out_ready;

  // Slots already spoken for at the end of this cycle. A pop in this cycle
  // frees its slot in time for a read issued now, which is what allows one
  // byte per cycle with only two entries.
  assign committed = {1'b0, fifo_count} + {2'b00, in_flight} - {2'b00, pop};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    issue       = 1'b0;
    accept      = 1'b0;
    accept_zero = 1'b0;
    last_pop    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (length == '0) begin
            accept_zero = 1'b1;
          end else begin
            state_nxt = READ;
          end
        end
      end
      READ: begin
        if (committed < CREDIT) begin
          issue = 1'b1;
          if (issue_rem == LEN_W'(1)) begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && (deliver_rem == LEN_W'(1))) begin
          last_pop  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_cnt    <= '0;
      last_addr   <= '0;
      issue_rem   <= '0;
      deliver_rem <= '0;
      in_flight   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      if (accept) begin
        addr_cnt    <= start_addr;
        issue_rem   <= length;
        deliver_rem <= length;
      end else begin
        if (issue) begin
          addr_cnt  <= addr_cnt + ADDR_W'(1);
          issue_rem <= issue_rem - LEN_W'(1);
          last_addr <= addr_cnt;
        end
        if (pop) begin
          deliver_rem <= deliver_rem - LEN_W'(1);
        end
      end
      in_flight <= issue;
      done_q    <= accept_zero | last_pop;
    end
  end

  // The ROM data for a read issued last cycle is on rom_dout now and is
  // captured at this clock edge.
  rom_reader_fifo2 #(
    .DATA_W(DATA_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (in_flight),
    .push_data(rom_dout),
    .pop      (pop),
    .head     (fifo_head),
    .count    (fifo_count)
  );

  assign busy     = (state != IDLE);
  assign done     = done_q;
  assign rom_cs   = issue;
  assign rom_addr = issue ? addr_cnt : last_addr;
  assign out_data = fifo_head;

endmodule

// File: tb/tb_rom_burst_reader.sv
module tb_rom_burst_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] start_addr;
  logic [8:0] length;
  logic       busy;
  logic       done;
  logic       rom_cs;
  logic [7:0] rom_addr;
  logic [7:0] rom_dout;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  logic [7:0] rom_mem [256];
  logic [7:0] rom_q = 8'h00;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0] exp_addr_q [$];
  logic [7:0] exp_data_q [$];
  int n_iss, n_del, n_done, cyc, first_v, done_cyc;

  rom_burst_reader #(
    .ADDR_W(8),
    .DATA_W(8),
    .LEN_W (9)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .start_addr(start_addr),
    .length    (length),
    .busy      (busy),
    .done      (done),
    .rom_cs    (rom_cs),
    .rom_addr  (rom_addr),
    .rom_dout  (rom_dout),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  // synchronous ROM macro model, one cycle read latency
  always @(posedge clk) begin
    if (rom_cs) rom_q <= rom_mem[rom_addr];
  end
  assign rom_dout = rom_q;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, then sample.
  task automatic cycle(input bit rdy, input bit st, input logic [7:0] sa, input logic [8:0] ln);
    @(negedge clk);
    out_ready  = rdy;
    start      = st;
    start_addr = sa;
    length     = ln;
    #1;
    if (rom_cs) begin
      if (exp_addr_q.size() == 0) chk("cs_unexpected", 32'(rom_cs), 0);
      else chk("rom_addr", 32'(rom_addr), 32'(exp_addr_q.pop_front()));
      n_iss++;
    end
    if (out_valid && out_ready) begin
      if (exp_data_q.size() == 0) chk("byte_unexpected", 32'(out_valid), 0);
      else chk("out_data", 32'(out_data), 32'(exp_data_q.pop_front()));
      n_del++;
    end
    chk("outstanding_le_2", 32'(n_iss - n_del <= 2), 1);
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (out_valid && first_v < 0) first_v = cyc;
    cyc++;
  endtask

  // mode 0: ready held high; 1: random ready; 2: 1,0,0,1 pattern with a 10-cycle stall
  task automatic run_burst(input logic [7:0] sa, input int ln, input int mode, input int inject_at);
    bit rdy;
    bit [3:0] pat = 4'b1001;
    int budget = ln * 4 + 40;
    n_iss = 0; n_del = 0; n_done = 0; cyc = 0; first_v = -1; done_cyc = -1;
    for (int k = 0; k < ln; k++) begin
      logic [7:0] a;
      a = 8'((int'(sa) + k) % 256);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(rom_mem[a]);
    end
    cycle(1'b1, 1'b1, sa, 9'(ln));
    chk("busy_at_start", 32'(busy), 0);
    while (n_done == 0 && cyc < budget) begin
      case (mode)
        0: rdy = 1'b1;
        1: rdy = 1'($urandom_range(0, 1));
        default: rdy = (cyc >= 8 && cyc < 18) ? 1'b0 : pat[cyc % 4];
      endcase
      if (cyc == inject_at) chk("busy_when_injected", 32'(busy), 1);
      cycle(rdy, cyc == inject_at, 8'h77, 9'd3);
    end
    chk("done_seen", 32'(n_done), 1);
    chk("busy_low_at_done", 32'(busy), 0);
    chk("issue_count", 32'(n_iss), 32'(ln));
    chk("deliver_count", 32'(n_del), 32'(ln));
    chk("model_empty", 32'(exp_data_q.size()), 0);
    if (mode == 0) begin
      chk("done_cycle", 32'(done_cyc), (ln == 0) ? 1 : 32'(ln + 3));
      if (ln > 0) chk("first_valid_cycle", 32'(first_v), 3);
    end
    cycle(1'b1, 1'b0, 8'h00, 9'd0);
    chk("done_single_pulse", 32'(done), 0);
    chk("idle_no_cs", 32'(rom_cs), 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'(i) ^ 8'h5A;
    rst = 1'b1; start = 1'b0; start_addr = '0; length = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_rom_cs", 32'(rom_cs), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    @(negedge clk);
    rst = 1'b0;

    run_burst(8'h10, 4, 0, -1);      // basic
    run_burst(8'hFE, 4, 0, -1);      // address wrap
    run_burst(8'h40, 8, 2, -1);      // backpressure
    run_burst(8'h33, 0, 0, -1);      // zero length
    run_burst(8'h30, 16, 0, 5);      // start while busy ignored
    run_burst(8'h00, 257, 1, -1);    // full ROM plus one

    // reset in the middle of a 16-byte burst
    n_iss = 0; n_del = 0; cyc = 0; first_v = -1;
    for (int k = 0; k < 16; k++) begin
      exp_addr_q.push_back(8'(8'h50 + k));
      exp_data_q.push_back(rom_mem[8'(8'h50 + k)]);
    end
    cycle(1'b1, 1'b1, 8'h50, 9'd16);
    repeat (4) cycle(1'b1, 1'b0, 8'h00, 9'd0);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_rom_cs", 32'(rom_cs), 0);
    chk("midrst_rom_addr", 32'(rom_addr), 0);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_out_data", 32'(out_data), 0);
    exp_addr_q.delete();
    exp_data_q.delete();
    @(negedge clk);
    rst = 1'b0;
    run_burst(8'h20, 2, 0, -1);

    // random ROM contents and bursts under random backpressure
    for (int i = 0; i < 256; i++) rom_mem[i] = 8'($urandom);
    for (int t = 0; t < 5; t++) begin
      run_burst(8'($urandom), int'($urandom_range(1, 40)), 1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
